// File: rtl/sram_access_ctrl_pkg.sv
// Shared constants and types for the SRAM access controller.
//   H_RES_DEF/V_RES_DEF : default frame geometry
//   RGB565_W            : pixel word width
//   state_e             : controller FSM encoding
//   window_t            : latched write window {XS, XE, YS, YE}
package sram_access_ctrl_pkg;

    localparam int unsigned H_RES_DEF = 320;
    localparam int unsigned V_RES_DEF = 240;
    localparam int unsigned RGB565_W  = 16;
    localparam int unsigned COORD_W   = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] xs;
        logic [COORD_W-1:0] xe;
        logic [COORD_W-1:0] ys;
        logic [COORD_W-1:0] ye;
    } window_t;

endpackage

// File: rtl/pix_wr_fifo.sv
// Synchronous FIFO holding pending {address, pixel} writes.
//   clk, rst_n : clock, async active-low reset
//   flush      : drop all entries (wins over push/pop)
//   push/wdata : enqueue; caller only pushes when !full or popping
//   pop/rdata  : dequeue; rdata shows the head entry
//   empty/full : occupancy flags
module pix_wr_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned PW    = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

    // Pointers carry an extra wrap bit to tell full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; occupancy is governed by the pointers.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q[PTR_W-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr_q[PTR_W-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

endmodule

// File: rtl/sram_access_ctrl.sv
// Arbitrates a single-port frame-buffer SRAM between video reads, a
// full-frame clear sweep and windowed pixel writes from the SPI decoder.
//   i_clk, i_rst_n            : clock, async active-low reset
//   i_pixel_data, i_write_req : pixel write stream
//   i_col_addr, i_row_addr    : window {XS,XE} / {YS,YE}, loaded on i_waddr_set_req
//   i_clr_req                 : start (or restart) a frame clear
//   i_rd_req, i_rd_addr       : video reads, always granted
//   o_rd_data, o_rd_valid     : read return
//   o_sram_*, i_sram_rdata    : SRAM port
//   o_busy, o_overflow        : clear in progress, sticky dropped-pixel flag
module sram_access_ctrl
    import sram_access_ctrl_pkg::*;
#(
    parameter int unsigned H_RES      = H_RES_DEF,
    parameter int unsigned V_RES      = V_RES_DEF,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [15:0]         i_pixel_data,
    input  logic [31:0]         i_col_addr,
    input  logic [31:0]         i_row_addr,
    input  logic                i_write_req,
    input  logic                i_waddr_set_req,
    input  logic                i_clr_req,
    input  logic                i_rd_req,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output logic [15:0]         o_rd_data,
    output logic                o_rd_valid,
    output logic [ADDR_W-1:0]   o_sram_addr,
    output logic [15:0]         o_sram_wdata,
    output logic                o_sram_we,
    output logic                o_sram_re,
    input  logic [15:0]         i_sram_rdata,
    output logic                o_busy,
    output logic                o_overflow
);

    localparam int unsigned PIX_N = H_RES * V_RES;
    localparam int unsigned ENT_W = ADDR_W + RGB565_W;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     clr_cnt_q, clr_cnt_d;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;
    window_t               win_q, win_d, win_e;
    logic [COORD_W-1:0]    x_q, x_d, y_q, y_d, x_e, y_e;
    logic [ADDR_W-1:0]     sram_addr_q, sram_addr_d;
    logic [15:0]           sram_wdata_q, sram_wdata_d;
    logic                  sram_we_q, sram_we_d, sram_re_q, sram_re_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
    logic [ENT_W-1:0]      fifo_rdata;
    logic [ADDR_W-1:0]     pix_addr;
    logic                  in_range, wr_ok;

    // A set pulse takes effect for a write in the same cycle.
    assign win_e    = i_waddr_set_req ? window_t'({i_col_addr, i_row_addr}) : win_q;
    assign x_e      = i_waddr_set_req ? i_col_addr[31:16] : x_q;
    assign y_e      = i_waddr_set_req ? i_row_addr[31:16] : y_q;
    assign pix_addr = ADDR_W'(32'(y_e) * H_RES + 32'(x_e));
    assign in_range = (32'(x_e) < H_RES) && (32'(y_e) < V_RES);
    // Writes are discarded while clearing, including the cycle a clear starts.
    assign wr_ok    = i_write_req && (state_q == ST_IDLE) && !i_clr_req;

    pix_wr_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata ({pix_addr, i_pixel_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Next-state: cursor, SRAM slot arbitration (read > clear > FIFO), clear FSM.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        busy_d       = busy_q;
        ovf_d        = ovf_q;
        win_d        = win_e;
        x_d          = x_e;
        y_d          = y_e;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_we_d    = 1'b0;
        sram_re_d    = 1'b0;
        rd_valid_d   = sram_re_q;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        fifo_flush   = 1'b0;

        if (wr_ok) begin
            if (x_e == win_e.xe) begin
                x_d = win_e.xs;
                y_d = (y_e == win_e.ye) ? win_e.ys : y_e + COORD_W'(1);
            end else begin
                x_d = x_e + COORD_W'(1);
            end
        end

        if (i_rd_req) begin
            sram_re_d   = 1'b1;
            sram_addr_d = i_rd_addr;
        end else if (state_q == ST_CLEAR && !i_clr_req) begin
            sram_we_d    = 1'b1;
            sram_addr_d  = clr_cnt_q;
            sram_wdata_d = '0;
            if (clr_cnt_q == ADDR_W'(PIX_N - 1)) begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
        end else if (state_q == ST_IDLE && !fifo_empty && !i_clr_req) begin
            fifo_pop     = 1'b1;
            sram_we_d    = 1'b1;
            sram_addr_d  = fifo_rdata[ENT_W-1 -: ADDR_W];
            sram_wdata_d = fifo_rdata[RGB565_W-1:0];
        end

        // A pop in the same cycle frees the slot a full FIFO needs.
        if (wr_ok && in_range) begin
            if (!fifo_full || fifo_pop) fifo_push = 1'b1;
            else                        ovf_d     = 1'b1;
        end

        if (i_clr_req) begin
            state_d    = ST_CLEAR;
            clr_cnt_d  = '0;
            busy_d     = 1'b1;
            ovf_d      = 1'b0;
            fifo_flush = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= '0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            win_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_q    <= 1'b0;
            sram_re_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
            win_q        <= win_d;
            x_q          <= x_d;
            y_q          <= y_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_q    <= sram_we_d;
            sram_re_q    <= sram_re_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign o_sram_addr  = sram_addr_q;
    assign o_sram_wdata = sram_wdata_q;
    assign o_sram_we    = sram_we_q;
    assign o_sram_re    = sram_re_q;
    assign o_busy       = busy_q;
    assign o_overflow   = ovf_q;
    assign o_rd_valid   = rd_valid_q;
    // SRAM returns data in the cycle o_rd_valid is high, so it is forwarded gated.
    assign o_rd_data    = rd_valid_q ? i_sram_rdata : '0;

endmodule
